mac_seq: RTL and testbench

- Parametrised sequential multiply-accumulate unit: radix-2 shift-add multiplier feeding a wide accumulator.
- Operands are accepted through a valid/ready handshake.
- Supports unsigned and two's-complement operands, selected per operation; overflow handling is selectable (wrap or saturate).
- Sits in the MAC datapath as the next-generation replacement for the fixed-width combinational array multiplier.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/mac_seq_if.sv | 31 +++
 rtl/mult_seq_core.sv | 73 +++++++
 rtl/mac_seq.sv | 184 ++++++++++++++++++
 tb/tb_mac_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the sequential multiply-accumulate unit:
// FSM encoding, default accumulator width and saturation limits.
package mac_pkg;

    localparam int MAX_ACC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int default_acc_width(input int width);
        return 2 * width + 4;
    endfunction

    // Limits are returned in a 64-bit container; callers truncate to their width.
    function automatic logic [MAX_ACC_W-1:0] umax_f(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] smax_f(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] smin_f(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Operand/result handshake bundle of mac_seq. The producer/consumer side
// uses the master modport, the MAC itself the slave modport.
interface mac_seq_if
    import mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = default_acc_width(WIDTH)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, acc_clr, out_ready,
        input  in_ready, out_valid, acc, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, acc_clr, out_ready,
        output in_ready, out_valid, acc, ovf, busy
    );

endinterface

// File: rtl/mult_seq_core.sv
// Radix-2 shift-add unsigned multiplier: one partial-product step per clock,
// WIDTH steps after start. Operates on magnitudes only.
module mult_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;

    // Load on start, otherwise one conditional add and shift per running cycle.
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            prod_d   = {(2*WIDTH){1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end else begin
                prod_d = prod_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            run_d    = (cnt_q != CNT_LAST);
        end else begin
            run_d = 1'b0;
        end
    end

    // Iteration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= {(2*WIDTH){1'b0}};
            prod_q   <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // High during the final iteration so the caller can leave MUL on the
    // same edge that writes the last partial product.
    assign done    = run_q & (cnt_q == CNT_LAST);
    assign product = prod_q;

endmodule

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate unit: handshake FSM, sign handling and a
// wide accumulator with wrap or saturate overflow policy around mult_seq_core.
module mac_seq
    import mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = default_acc_width(WIDTH),
    parameter int SATURATE  = 0
) (
    input logic      clk,
    input logic      rst,
    mac_seq_if.slave bus
);
    if (ACC_WIDTH < 2 * WIDTH || ACC_WIDTH > MAX_ACC_W || WIDTH < 2) begin : g_bad_params
        $error("mac_seq: need WIDTH >= 2 and 2*WIDTH <= ACC_WIDTH <= 64");
    end

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic                 smode_q, smode_d;
    logic                 clr_q, clr_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic                 start_s;
    logic                 mul_done_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [2*WIDTH-1:0]   prod_mag_s;
    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 ovf_now_s;
    logic [ACC_WIDTH-1:0] sat_lim_s;

    // Control FSM; flag outputs are decoded from the next state and registered.
    always_comb begin
        state_d = state_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    start_s = 1'b1;
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_ACC: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Operand capture: magnitudes go to the core, sign and mode stay here.
    always_comb begin
        if (bus.signed_mode && bus.a[WIDTH-1]) begin
            a_mag_s = -bus.a;
        end else begin
            a_mag_s = bus.a;
        end
        if (bus.signed_mode && bus.b[WIDTH-1]) begin
            b_mag_s = -bus.b;
        end else begin
            b_mag_s = bus.b;
        end
        if (start_s) begin
            sign_d  = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            smode_d = bus.signed_mode;
            clr_d   = bus.acc_clr;
        end else begin
            sign_d  = sign_q;
            smode_d = smode_q;
            clr_d   = clr_q;
        end
    end

    mult_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .a_mag   (a_mag_s),
        .b_mag   (b_mag_s),
        .product (prod_mag_s),
        .done    (mul_done_s)
    );

    // Signed products never exceed 2^(2*WIDTH-2), so zero-extending the
    // magnitude before negation is also a correct sign extension.
    always_comb begin
        if (sign_q) begin
            prod_ext_s = -ACC_WIDTH'(prod_mag_s);
        end else begin
            prod_ext_s = ACC_WIDTH'(prod_mag_s);
        end
        sum_s = {1'b0, acc_q} + {1'b0, prod_ext_s};
        if (smode_q) begin
            ovf_now_s = (acc_q[ACC_WIDTH-1] == prod_ext_s[ACC_WIDTH-1]) &&
                        (sum_s[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            ovf_now_s = sum_s[ACC_WIDTH];
        end
        if (!smode_q) begin
            sat_lim_s = ACC_WIDTH'(umax_f(ACC_WIDTH));
        end else if (acc_q[ACC_WIDTH-1]) begin
            sat_lim_s = ACC_WIDTH'(smin_f(ACC_WIDTH));
        end else begin
            sat_lim_s = ACC_WIDTH'(smax_f(ACC_WIDTH));
        end
    end

    // Accumulator update happens only in ACC; ovf is sticky until a clearing op.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (state_q == ST_ACC) begin
            if (clr_q) begin
                acc_d = prod_ext_s;
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q | ovf_now_s;
                if (ovf_now_s && (SATURATE != 0)) begin
                    acc_d = sat_lim_s;
                end else begin
                    acc_d = sum_s[ACC_WIDTH-1:0];
                end
            end
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            smode_q     <= 1'b0;
            clr_q       <= 1'b0;
            acc_q       <= {ACC_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            smode_q     <= smode_d;
            clr_q       <= clr_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq at WIDTH=3, ACC_WIDTH=10: a wrapping and a
// saturating instance share the same stimulus.
module tb_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mac_seq_if #(.WIDTH(3), .ACC_WIDTH(10)) if0 ();
    mac_seq_if #(.WIDTH(3), .ACC_WIDTH(10)) if1 ();

    assign if1.in_valid    = if0.in_valid;
    assign if1.a           = if0.a;
    assign if1.b           = if0.b;
    assign if1.signed_mode = if0.signed_mode;
    assign if1.acc_clr     = if0.acc_clr;
    assign if1.out_ready   = if0.out_ready;

    mac_seq #(.WIDTH(3), .ACC_WIDTH(10), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mac_seq #(.WIDTH(3), .ACC_WIDTH(10), .SATURATE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        int a;
        int b;
        int sm;
        int clr;
        int exp0;
        int exp1;
        int eovf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present one operand set, wait for out_valid on both units; lat counts edges after accept.
    task automatic run_op(input int a, input int b, input int sm, input int clr, output int lat);
        @(negedge clk);
        if0.a           = 3'(a);
        if0.b           = 3'(b);
        if0.signed_mode = 1'(sm);
        if0.acc_clr     = 1'(clr);
        if0.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        lat = 0;
        while (!(if0.out_valid && if1.out_valid) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        if0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        vecs[0]  = '{7, 7, 0, 1,   49,   49, 0};
        vecs[1]  = '{5, 6, 0, 1,   30,   30, 0};
        vecs[2]  = '{3, 2, 0, 0,   36,   36, 0};
        vecs[3]  = '{4, 4, 1, 1,   16,   16, 0};
        vecs[4]  = '{4, 3, 1, 0,    4,    4, 0};
        vecs[5]  = '{7, 1, 1, 0,    3,    3, 0};
        vecs[6]  = '{1, 1, 0, 1,    1,    1, 0};
        vecs[7]  = '{4, 3, 1, 1, 1012, 1012, 0};
        vecs[8]  = '{7, 7, 1, 0, 1013, 1013, 0};
        vecs[9]  = '{1, 1, 0, 0, 1014, 1014, 0};
        vecs[10] = '{7, 7, 0, 0,   39, 1023, 1};
        vecs[11] = '{1, 1, 1, 0,   40,    0, 1};
        vecs[12] = '{1, 1, 0, 1,    1,    1, 0};

        if0.in_valid    = 1'b0;
        if0.a           = 3'd0;
        if0.b           = 3'd0;
        if0.signed_mode = 1'b0;
        if0.acc_clr     = 1'b0;
        if0.out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_acc", if0.acc, 0);
        chk("rst_ovf", if0.ovf, 0);
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_in_ready", if0.in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].clr, lat);
            chk("vec_latency", lat, 4);
            chk("vec_acc_wrap", if0.acc, vecs[i].exp0);
            chk("vec_acc_sat", if1.acc, vecs[i].exp1);
            chk("vec_ovf_wrap", if0.ovf, vecs[i].eovf);
            chk("vec_ovf_sat", if1.ovf, vecs[i].eovf);
            take();
        end

        // 21 x 49 = 1029 exceeds 1023 on the last step
        for (int i = 0; i < 21; i++) begin
            run_op(7, 7, 0, (i == 0) ? 1 : 0, lat);
            take();
        end
        chk("ovf21_acc_wrap", if0.acc, 5);
        chk("ovf21_acc_sat", if1.acc, 1023);
        chk("ovf21_ovf_wrap", if0.ovf, 1);
        chk("ovf21_ovf_sat", if1.ovf, 1);
        run_op(1, 1, 0, 1, lat);
        chk("clr_acc_wrap", if0.acc, 1);
        chk("clr_acc_sat", if1.acc, 1);
        chk("clr_ovf_wrap", if0.ovf, 0);
        chk("clr_ovf_sat", if1.ovf, 0);
        take();

        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                run_op(ia, ib, 0, 1, lat);
                chk("sweep_acc_wrap", if0.acc, ia * ib);
                chk("sweep_acc_sat", if1.acc, ia * ib);
                take();
            end
        end

        // Backpressure: DONE must hold everything while in_valid and operands churn.
        run_op(2, 3, 0, 1, lat);
        chk("bp_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            if0.in_valid = (k % 2 == 0) ? 1'b1 : 1'b0;
            if0.a        = 3'(k + 3);
            if0.b        = 3'(k + 4);
            if0.acc_clr  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_acc", if0.acc, 6);
            chk("bp_out_valid", if0.out_valid, 1);
            chk("bp_in_ready", if0.in_ready, 0);
            chk("bp_ovf", if0.ovf, 0);
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.out_ready = 1'b0;
        chk("bp_rel_out_valid", if0.out_valid, 0);
        chk("bp_rel_in_ready", if0.in_ready, 1);
        chk("bp_rel_busy", if0.busy, 0);
        repeat (3) @(negedge clk);
        chk("bp_idle_busy", if0.busy, 0);
        chk("bp_idle_acc", if0.acc, 6);

        // Asynchronous reset during the second MUL cycle.
        @(negedge clk);
        if0.a           = 3'd7;
        if0.b           = 3'd7;
        if0.signed_mode = 1'b0;
        if0.acc_clr     = 1'b0;
        if0.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", if0.busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_acc", if0.acc, 0);
        chk("arst_ovf", if0.ovf, 0);
        chk("arst_out_valid", if0.out_valid, 0);
        chk("arst_busy", if0.busy, 0);
        chk("arst_in_ready", if0.in_ready, 1);
        chk("arst_in_ready_sat", if1.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run_op(2, 3, 0, 1, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_acc", if0.acc, 6);
        chk("post_rst_acc_sat", if1.acc, 6);
        take();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
